// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad front-end: key width, debounce FSM
// states and the one-hot test used to qualify a candidate key.
package keypad_pkg;

    localparam int KEY_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE_PRESS,
        PRESSED,
        DEBOUNCE_RELEASE
    } state_e;

    // True when exactly one bit is set: clearing the lowest set bit leaves zero.
    function automatic logic onehot8(input logic [KEY_W-1:0] v);
        return (v != '0) && ((v & (v - KEY_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser bringing the asynchronous switch lines into the clock
// domain before any decision is made on them.
module keypad_sync
    import keypad_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [KEY_W-1:0] d_i,
    output logic [KEY_W-1:0] q_o
);

    logic [KEY_W-1:0] s1_q;
    logic [KEY_W-1:0] s2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/keypad_debounce.sv
// Keypad conditioning: synchronise, reject chords, debounce press and release,
// and present a registered one-hot key with a one-cycle press strobe.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [KEY_W-1:0] raw_key,
    output logic [KEY_W-1:0] key,
    output logic             key_strobe,
    output logic             key_held
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_W-1:0] sync_key;
    logic [KEY_W-1:0] cand;

    state_e           state_q,  state_d;
    logic [KEY_W-1:0] pend_q,   pend_d;
    logic [KEY_W-1:0] key_q,    key_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             strobe_q, strobe_d;
    logic             held_q,   held_d;

    keypad_sync u_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (raw_key),
        .q_o   (sync_key)
    );

    // Chords and no-key both collapse to zero so neither can be accepted.
    assign cand = onehot8(sync_key) ? sync_key : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            key_q    <= '0;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            key_q    <= key_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            held_q   <= held_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        key_d    = key_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cand != '0) begin
                    pend_d  = cand;
                    cnt_d   = '0;
                    state_d = DEBOUNCE_PRESS;
                end
            end
            DEBOUNCE_PRESS: begin
                if (cand != pend_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    key_d    = pend_q;
                    strobe_d = 1'b1;
                    state_d  = PRESSED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                // Release, chord and a different key all go through a full release.
                if (cand != key_q) begin
                    cnt_d   = '0;
                    state_d = DEBOUNCE_RELEASE;
                end
            end
            DEBOUNCE_RELEASE: begin
                if (cand == key_q) begin
                    cnt_d   = '0;
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    key_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        held_d = (state_d == PRESSED) || (state_d == DEBOUNCE_RELEASE);
    end

    assign key        = key_q;
    assign key_strobe = strobe_q;
    assign key_held   = held_q;

endmodule

// File: doc/keypad_debounce.md
# keypad_debounce

Front-end conditioning stage for the keypad peripheral. It synchronises the eight raw switch lines, rejects bounce and multi-key chords, and presents a clean, stable one-hot `key` vector to the keypad bus interface, which encodes it. The output is either exactly one bit set or all zeros, never a transient or a chord. A one-cycle `key_strobe` marks each accepted press.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a press or release. Legal range ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: debounce counter width. Derived; do not override.

Ports:
- `CLK`  in  1  — single clock; all state updates on the rising edge.
- `RST`  in  1  — synchronous, active-high reset.
- `raw_key`  in  8  — asynchronous, active-high switch lines.
- `key`  out  8  — debounced one-hot key, or `8'h00` when no key is accepted.
- `key_strobe`  out  1  — one-cycle pulse in the cycle `key` takes a new non-zero value.
- `key_held`  out  1  — high while in PRESSED or DEBOUNCE_RELEASE, i.e. while `key` is non-zero.

## Operation
- **Synchroniser:** two flops, `raw_key → s1 → s2`.
- **Candidate:** `cand = s2` when `popcount(s2) == 1`, else `8'h00`. Chords and no-key both map to zero.
- **State machine:**
  - **IDLE** (`key = 0`): if `cand != 0`, then `pend <= cand`, `cnt <= 0`, go to DEBOUNCE_PRESS.
  - **DEBOUNCE_PRESS:**
    - If `cand != pend`, return to IDLE and set `cnt <= 0`.
    - Else if `cnt == DEBOUNCE_CYCLES-1`, then `key <= pend`, `key_strobe <= 1`, go to PRESSED.
    - Else `cnt <= cnt + 1`.
  - **PRESSED:** if `cand != key`, then `cnt <= 0`, go to DEBOUNCE_RELEASE. This covers release, a chord, and a different key.
  - **DEBOUNCE_RELEASE:**
    - If `cand == key`, set `cnt <= 0` and return to PRESSED, with no strobe.
    - Else if `cnt == DEBOUNCE_CYCLES-1`, then `key <= 0`, go to IDLE.
    - Else `cnt <= cnt + 1`.
- **Direct key change (A → B):** release A fully to IDLE (`key = 0` for at least one cycle), then run a fresh press debounce for B. The block never switches one-hot to one-hot directly.
- **Release:** produces no strobe.
- **Counter:** saturation is never reached; it is always cleared on state entry.

## Timing
- **Reset values:** state IDLE, `s1 = s2 = 0`, `pend = 0`, `cnt = 0`, `key = 8'h00`, `key_strobe = 0`, `key_held = 0`.
- **Reset behaviour:** `RST` is sampled on the rising edge and overrides all other logic. Reset mid-debounce aborts it with no strobe; any partial count is discarded.
- **Press latency:** with edge 1 being the first edge that samples a stable one-hot `raw_key`, `key` and `key_strobe` update on edge `DEBOUNCE_CYCLES+3`.
- **Strobe width:** `key_strobe` is high exactly one cycle.
- **Release latency:** `key` returns to 0 on edge `DEBOUNCE_CYCLES+3` after `raw_key` goes stable at a non-matching value.
- **Direct A → B change:**
  - `key = 0` at edge `N+3`.
  - `key = B` at edge `2N+4`, where `N = DEBOUNCE_CYCLES`.
- **Bounce:** any `cand` mismatch, even for a single cycle, restarts the debounce from the following cycle.
- **Outputs:** all registered; there is no combinational path from `raw_key`.

## Structure
- **Package `keypad_pkg`:**
  - `KEY_W = 8`.
  - State enum {IDLE, DEBOUNCE_PRESS, PRESSED, DEBOUNCE_RELEASE}.
  - `onehot8` function returning `popcount == 1`.
- **Sub-module `keypad_sync`:** the 8-bit two-flop synchroniser with synchronous reset. This is the only sub-module.
- **Top level:** FSM, counter, and output registers, all in `keypad_debounce`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4`.
1. **Clean press:** `raw_key = 8'h04` held 20 cycles, then `8'h00`.
   - `key = 8'h04` and one `key_strobe` at edge 7; `key_held = 1`.
   - After release, `key = 8'h00` at edge 7 post-release, with no strobe.
2. **Bounce:** `raw_key` alternates `8'h04`/`8'h00` every 2 cycles for 12 cycles, then holds `8'h04`.
   - No strobe during the bounce.
   - Exactly one strobe, with `key = 8'h04`, at edge 7 after the final stable edge.
3. **Chord:** `raw_key = 8'h05` for 30 cycles. `key` stays `8'h00`, no strobe, `key_held = 0`.
4. **Glitch while pressed:** accepted `8'h10`, then `raw_key = 8'h00` for 2 cycles, then `8'h10` again.
   - `key` stays `8'h10` throughout; no new strobe.
5. **Reset mid-debounce:** `raw_key = 8'h01`, `RST` high for one cycle at edge 5, `raw_key` held.
   - `key = 0` with no strobe before reset.
   - Strobe at edge 7 after reset deasserts.
6. **Direct change:** accepted `8'h02`, then `raw_key = 8'h40`.
   - `key = 8'h00` at edge 7, then `8'h40` with a second strobe at edge 12.
